// File: rtl/weight_load_sequencer_pkg.sv
// Shared definitions for the weight load sequencer: FSM encoding and counter sizing.
package weight_load_sequencer_pkg;

    localparam int DEFAULT_KS_WIDTH = 5;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ISSUE  = 3'd1;
    localparam logic [2:0] ST_DRAIN  = 3'd2;
    localparam logic [2:0] ST_COMMIT = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    // Word count K*K needs twice the kernel_size width.
    function automatic int count_width(input int ks_width);
        return 2 * ks_width;
    endfunction

endpackage

// File: rtl/weight_load_sequencer_valid_delay_line.sv
// Fixed-depth shift line for a single valid strobe, with synchronous flush.
module valid_delay_line #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else if (flush) begin
            sr <= '0;
        end else begin
            sr[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign dout = sr[DEPTH-1];

endmodule

// File: rtl/weight_load_sequencer.sv
// Streams K*K weight words from BRAM into the MAC preload bank, then commits them
// to the active weights once the array reports idle.
module weight_load_sequencer
    import weight_load_sequencer_pkg::*;
#(
    parameter int MAC_NUM            = 256,
    parameter int BRAM_ADDRESS_WIDTH = 12,
    parameter int BRAM_READ_LATENCY  = 2,
    parameter int KS_WIDTH           = DEFAULT_KS_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          abort,
    input  logic [KS_WIDTH-1:0]           kernel_size,
    input  logic [BRAM_ADDRESS_WIDTH-1:0] base_addr,
    input  logic                          array_idle,
    output logic                          bram_en,
    output logic [BRAM_ADDRESS_WIDTH-1:0] bram_addr,
    output logic                          load_weight_preload,
    output logic                          load_weight,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);

    localparam int CNT_W = count_width(KS_WIDTH);

    generate
        if (BRAM_READ_LATENCY < 1 || BRAM_READ_LATENCY > 4 || MAC_NUM < 1) begin : g_bad_param
            $error("weight_load_sequencer: unsupported parameter value");
        end
    endgenerate

    logic [2:0]       state;
    logic [CNT_W-1:0] n_words;
    logic [CNT_W-1:0] issue_cnt;
    logic [CNT_W-1:0] rcv_cnt;
    logic [CNT_W-1:0] rcv_next;
    logic             err_q;
    logic             abort_act;

    assign abort_act = abort && (state == ST_ISSUE || state == ST_DRAIN || state == ST_COMMIT);
    assign rcv_next  = rcv_cnt + CNT_W'(load_weight_preload);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            n_words   <= '0;
            issue_cnt <= '0;
            rcv_cnt   <= '0;
            err_q     <= 1'b0;
            bram_addr <= '0;
        end else begin
            rcv_cnt <= rcv_next;
            case (state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        if (kernel_size == '0) begin
                            state <= ST_DONE;
                            err_q <= 1'b1;
                        end else begin
                            state     <= ST_ISSUE;
                            // Multiplier sits here, once per burst, off the issue path.
                            n_words   <= CNT_W'(kernel_size) * CNT_W'(kernel_size);
                            bram_addr <= base_addr;
                            issue_cnt <= '0;
                            rcv_cnt   <= '0;
                            err_q     <= 1'b0;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else begin
                        issue_cnt <= issue_cnt + CNT_W'(1);
                        // Stop advancing on the last word so bram_addr holds it afterwards.
                        if (issue_cnt == n_words - CNT_W'(1)) begin
                            state <= ST_DRAIN;
                        end else begin
                            bram_addr <= bram_addr + BRAM_ADDRESS_WIDTH'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (rcv_next == n_words) begin
                        state <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (array_idle) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    err_q <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bram_en     = (state == ST_ISSUE);
    assign load_weight = (state == ST_COMMIT) && array_idle && !abort;
    assign busy        = (state != ST_IDLE);
    assign done        = (state == ST_DONE);
    assign err         = done && err_q;

    valid_delay_line #(
        .DEPTH(BRAM_READ_LATENCY)
    ) u_preload_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (abort_act),
        .din   (bram_en),
        .dout  (load_weight_preload)
    );

endmodule

// File: tb/tb_weight_load_sequencer.sv
// Scoreboard bench for weight_load_sequencer: directed bursts push expected events,
// a negedge monitor pops and compares every output event the DUT presents.
module tb_weight_load_sequencer;

    localparam int BAW = 12;
    localparam int KSW = 5;
    localparam int L   = 2;

    // Event kinds, in the order they are checked within one cycle.
    localparam int EV_BRAM = 0;
    localparam int EV_PRE  = 1;
    localparam int EV_LW   = 2;
    localparam int EV_DONE = 3;
    localparam int EV_ERR  = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           abort = 1'b0;
    logic [KSW-1:0] kernel_size = '0;
    logic [BAW-1:0] base_addr = '0;
    logic           array_idle = 1'b1;
    logic           bram_en;
    logic [BAW-1:0] bram_addr;
    logic           load_weight_preload;
    logic           load_weight;
    logic           busy;
    logic           done;
    logic           err;

    weight_load_sequencer #(
        .MAC_NUM            (256),
        .BRAM_ADDRESS_WIDTH (BAW),
        .BRAM_READ_LATENCY  (L),
        .KS_WIDTH           (KSW)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .start               (start),
        .abort               (abort),
        .kernel_size         (kernel_size),
        .base_addr           (base_addr),
        .array_idle          (array_idle),
        .bram_en             (bram_en),
        .bram_addr           (bram_addr),
        .load_weight_preload (load_weight_preload),
        .load_weight         (load_weight),
        .busy                (busy),
        .done                (done),
        .err                 (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int cyc;
        int val;
    } ev_t;

    ev_t q[$];
    int  cyc = 0;
    int  n_cmp = 0;
    int  n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            EV_BRAM: return "bram_en";
            EV_PRE:  return "preload";
            EV_LW:   return "load_weight";
            EV_DONE: return "done";
            default: return "err_without_done";
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic see(input int kind, input int val);
        ev_t e;
        n_cmp++;
        if (q.size() == 0) begin
            n_bad++;
            $display("FAIL spurious_%s: got event at cycle %0d val %0h, expected no event",
                     kname(kind), cyc, val);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || e.cyc != cyc || e.val != val) begin
                n_bad++;
                $display("FAIL event_%s: got %s@%0d val %0h, expected %s@%0d val %0h",
                         kname(e.kind), kname(kind), cyc, val, kname(e.kind), e.cyc, e.val);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bram_en)             see(EV_BRAM, int'(bram_addr));
            if (load_weight_preload) see(EV_PRE, 0);
            if (load_weight)         see(EV_LW, 0);
            if (done)                see(EV_DONE, int'(err));
            if (err && !done)        see(EV_ERR, 1);
        end
    end

    task automatic push(input int kind, input int c, input int val);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.val  = val;
        q.push_back(e);
    endtask

    // Expected events for a burst started in cycle s. Commit lands in lw_cyc, done one
    // cycle later. When cut >= 0 the burst is cancelled after cycle cut: nothing after it.
    task automatic expect_burst(input int s, input int k, input int base,
                                input int lw_cyc, input int cut);
        int n = k * k;
        for (int c = s + 1; c <= lw_cyc + 1; c++) begin
            int i = c - s - 1;
            int j = c - s - 1 - L;
            if (cut < 0 || c <= cut) begin
                if (i >= 0 && i < n) push(EV_BRAM, c, (base + i) % 4096);
                if (j >= 0 && j < n) push(EV_PRE, c, 0);
            end
            if (cut < 0 && c == lw_cyc)     push(EV_LW, c, 0);
            if (cut < 0 && c == lw_cyc + 1) push(EV_DONE, c, 0);
        end
    endtask

    task automatic goto_cycle(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue_start(input int k, input int base, output int s);
        @(posedge clk);
        #1;
        s           = cyc;
        kernel_size = KSW'(k);
        base_addr   = BAW'(base);
        start       = 1'b1;
    endtask

    task automatic end_start;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic drain(input string name, input int c_end);
        goto_cycle(c_end);
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL pending_%s: got %0d events outstanding, expected 0", name, q.size());
        end
        q.delete();
    endtask

    initial begin
        int s;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_bram_en", bram_en, 0);
        chk("reset_addr", bram_addr, 0);
        chk("reset_preload", load_weight_preload, 0);
        chk("reset_busy_done_err_lw", {busy, done, err, load_weight}, 0);
        rst_n = 1'b1;

        // K=3, base 0x010: nine reads, commit at s+12, done 13 cycles after start.
        issue_start(3, 'h010, s);
        expect_burst(s, 3, 'h010, s + 12, -1);
        end_start();
        goto_cycle(s + 13);
        chk("k3_busy_at_done", busy, 1);
        goto_cycle(s + 14);
        chk("k3_busy_after_done", busy, 0);
        drain("k3", s + 16);

        // K=1 at the top of the address space.
        issue_start(1, 'hFFF, s);
        expect_burst(s, 1, 'hFFF, s + 4, -1);
        end_start();
        drain("k1_fff", s + 8);

        // K=2 wrapping through zero.
        issue_start(2, 'hFFE, s);
        expect_burst(s, 2, 'hFFE, s + 7, -1);
        end_start();
        drain("k2_wrap", s + 10);

        // Array busy for 5 cycles after the last preload (s+11): commit at s+17.
        array_idle = 1'b0;
        issue_start(3, 'h100, s);
        expect_burst(s, 3, 'h100, s + 17, -1);
        end_start();
        goto_cycle(s + 17);
        array_idle = 1'b1;
        drain("k3_idle_wait", s + 21);

        // Abort on the 4th issue cycle.
        issue_start(3, 'h200, s);
        expect_burst(s, 3, 'h200, s + 12, s + 4);
        end_start();
        goto_cycle(s + 4);
        abort = 1'b1;
        goto_cycle(s + 5);
        abort = 1'b0;
        chk("abort_bram_en_next", bram_en, 0);
        chk("abort_busy_next", busy, 0);
        drain("abort", s + 15);

        // Clean burst after abort.
        issue_start(2, 'h020, s);
        expect_burst(s, 2, 'h020, s + 7, -1);
        end_start();
        drain("after_abort", s + 10);

        // K=0: done and err together in the cycle after start.
        issue_start(0, 'h055, s);
        push(EV_DONE, s + 1, 1);
        end_start();
        drain("k0_err", s + 5);

        // Start pulsed mid-burst is ignored.
        issue_start(2, 'h040, s);
        expect_burst(s, 2, 'h040, s + 7, -1);
        end_start();
        goto_cycle(s + 3);
        kernel_size = KSW'(3);
        base_addr   = BAW'('h300);
        start       = 1'b1;
        goto_cycle(s + 4);
        start = 1'b0;
        drain("start_busy", s + 12);

        // Reset asserted in DRAIN.
        issue_start(3, 'h080, s);
        expect_burst(s, 3, 'h080, s + 12, s + 9);
        end_start();
        goto_cycle(s + 10);
        rst_n = 1'b0;
        #2;
        chk("rst_drain_preload", load_weight_preload, 0);
        chk("rst_drain_ctrl", {bram_en, busy, done, err, load_weight}, 0);
        chk("rst_drain_addr", bram_addr, 0);
        goto_cycle(s + 12);
        rst_n = 1'b1;
        drain("rst_drain", s + 18);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
